// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// ID-stage hazard detector built around a per-register countdown scoreboard.
// Each architectural register r has a small down-counter cnt[r] holding the
// number of bubbles a consumer of r must still wait before the in-flight
// write can be read. The instruction in ID is stalled while any of its valid
// sources has a nonzero counter.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   freeze          whole pipeline held; counters and stall_count hold
//   flush           instruction in ID is cancelled (does not issue)
//   ignore_hazard   instruction in ID has no register sources
//   src_addr        flattened source addresses, source i at [i*REG_ADDR_W +: REG_ADDR_W]
//   src_valid       per-source "operand actually read"
//   id_valid        ID holds a real instruction
//   dest_addr       destination register of the instruction in ID
//   dest_wb_en      instruction in ID writes dest_addr
//   dest_is_load    instruction in ID is a load
//   hazard_detected stall request for the instruction in ID
//   issue           instruction in ID advances this cycle
//   pending_mask    bit r set while cnt[r] != 0
//   stall_count     saturating count of non-frozen hazard cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_ADDR_W    = 4,
  parameter int NUM_REGS      = 16,
  parameter int NUM_SRC       = 3,
  parameter int FORWARDING_EN = 1,
  parameter int LOAD_LAT      = 1,
  parameter int ALU_LAT       = 0,
  parameter int NOFWD_LAT     = 2,
  parameter int CNT_W         = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          freeze,
  input  logic                          flush,
  input  logic                          ignore_hazard,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic                          id_valid,
  input  logic [REG_ADDR_W-1:0]         dest_addr,
  input  logic                          dest_wb_en,
  input  logic                          dest_is_load,
  output logic                          hazard_detected,
  output logic                          issue,
  output logic [NUM_REGS-1:0]           pending_mask,
  output logic [31:0]                   stall_count
);

  localparam logic [CNT_W-1:0] LOAD_L  = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] ALU_L   = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] NOFWD_L = CNT_W'(NOFWD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]      cnt     [NUM_REGS];
  logic [CNT_W-1:0]      cnt_dec [NUM_REGS];
  logic [CNT_W-1:0]      cnt_nxt [NUM_REGS];
  logic [REG_ADDR_W-1:0] src_a   [NUM_SRC];
  logic [CNT_W-1:0]      wr_lat;
  logic                  src_hit;
  logic                  wr_set;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_a[i] = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
  end

  // Sources are checked against the current (old) counters only, so an
  // instruction reading its own destination never stalls on itself.
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && (cnt[src_a[i]] != '0)) begin
        src_hit = 1'b1;
      end
    end
  end

  assign hazard_detected = ~ignore_hazard & id_valid & src_hit;
  assign issue           = id_valid & ~hazard_detected & ~freeze & ~flush;
  assign wr_set          = issue & dest_wb_en;

  always_comb begin
    if (FORWARDING_EN != 0) begin
      wr_lat = dest_is_load ? LOAD_L : ALU_L;
    end else begin
      wr_lat = NOFWD_L;
    end
  end

  // Decrement saturates at zero; a new writer may only raise a counter, so a
  // slow older write is never hidden by a faster younger one (WAW ordering).
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign cnt_dec[r] = (cnt[r] != '0) ? (cnt[r] - CNT_ONE) : cnt[r];

    always_comb begin
      cnt_nxt[r] = cnt_dec[r];
      if (wr_set && (dest_addr == REG_ADDR_W'(r)) && (wr_lat > cnt_dec[r])) begin
        cnt_nxt[r] = wr_lat;
      end
    end

    assign pending_mask[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      stall_count <= '0;
    end else if (!freeze) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      if (hazard_detected && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        ignore_hazard = 1'b0;
  logic        id_valid = 1'b0;
  logic        dest_wb_en = 1'b0;
  logic        dest_is_load = 1'b0;
  logic [11:0] src_addr = '0;
  logic [2:0]  src_valid = '0;
  logic [3:0]  dest_addr = '0;

  logic [NI-1:0] haz;
  logic [NI-1:0] iss;
  logic [15:0]   pm [NI];
  logic [31:0]   sc [NI];

  // instance 0: forwarding, load 1, alu 0
  hazard_scoreboard #(.FORWARDING_EN(1), .LOAD_LAT(1), .ALU_LAT(0), .NOFWD_LAT(2)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .ignore_hazard(ignore_hazard),
    .src_addr(src_addr), .src_valid(src_valid), .id_valid(id_valid), .dest_addr(dest_addr),
    .dest_wb_en(dest_wb_en), .dest_is_load(dest_is_load),
    .hazard_detected(haz[0]), .issue(iss[0]), .pending_mask(pm[0]), .stall_count(sc[0]));

  // instance 1: no forwarding, every writer 2
  hazard_scoreboard #(.FORWARDING_EN(0), .LOAD_LAT(1), .ALU_LAT(0), .NOFWD_LAT(2)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .ignore_hazard(ignore_hazard),
    .src_addr(src_addr), .src_valid(src_valid), .id_valid(id_valid), .dest_addr(dest_addr),
    .dest_wb_en(dest_wb_en), .dest_is_load(dest_is_load),
    .hazard_detected(haz[1]), .issue(iss[1]), .pending_mask(pm[1]), .stall_count(sc[1]));

  // instance 2: forwarding, load 2, alu 0
  hazard_scoreboard #(.FORWARDING_EN(1), .LOAD_LAT(2), .ALU_LAT(0), .NOFWD_LAT(2)) dut_ld2 (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .ignore_hazard(ignore_hazard),
    .src_addr(src_addr), .src_valid(src_valid), .id_valid(id_valid), .dest_addr(dest_addr),
    .dest_wb_en(dest_wb_en), .dest_is_load(dest_is_load),
    .hazard_detected(haz[2]), .issue(iss[2]), .pending_mask(pm[2]), .stall_count(sc[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a register is readable from the (non-frozen) cycle
  // number ready_at onward; tick counts non-frozen cycles since reset.
  longint      ready_at [NI][16];
  longint      tick     [NI];
  logic [31:0] m_stall  [NI];
  bit          model_ok = 0;

  typedef struct packed {
    logic [NI-1:0]        haz;
    logic [NI-1:0]        iss;
    logic [NI-1:0][15:0]  pm;
    logic [NI-1:0][31:0]  sc;
  } exp_t;

  exp_t exp_q [$];

  function automatic int lat_of(int k, logic ld);
    case (k)
      0:       return ld ? 1 : 0;
      1:       return 2;
      default: return ld ? 2 : 0;
    endcase
  endfunction

  function automatic logic m_haz(int k);
    logic h;
    h = 1'b0;
    if (!ignore_hazard && id_valid) begin
      for (int i = 0; i < 3; i++) begin
        if (src_valid[i] && (ready_at[k][src_addr[i*4 +: 4]] > tick[k])) h = 1'b1;
      end
    end
    return h;
  endfunction

  function automatic logic m_issue(int k);
    return id_valid && !m_haz(k) && !freeze && !flush;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      e.haz[k] = m_haz(k);
      e.iss[k] = m_issue(k);
      for (int r = 0; r < 16; r++) e.pm[k][r] = (ready_at[k][r] > tick[k]);
      e.sc[k] = m_stall[k];
    end
    exp_q.push_back(e);
  endtask

  task automatic update_model();
    logic   h, is;
    longint nr;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        tick[k] = 0;
        m_stall[k] = '0;
        for (int r = 0; r < 16; r++) ready_at[k][r] = 0;
      end else if (!freeze) begin
        h  = m_haz(k);
        is = m_issue(k);
        if (h && (m_stall[k] != 32'hFFFF_FFFF)) m_stall[k] = m_stall[k] + 32'd1;
        if (is && dest_wb_en) begin
          nr = tick[k] + 1 + lat_of(k, dest_is_load);
          if (nr > ready_at[k][dest_addr]) ready_at[k][dest_addr] = nr;
        end
        tick[k] = tick[k] + 1;
      end
    end
    if (!rst_n) model_ok = 1;
  endtask

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", nm, k, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        check("hazard_detected", k, 32'(haz[k]), 32'(e.haz[k]));
        check("issue",           k, 32'(iss[k]), 32'(e.iss[k]));
        check("pending_mask",    k, 32'(pm[k]),  32'(e.pm[k]));
        check("stall_count",     k, sc[k],       e.sc[k]);
      end
    end
  end

  task automatic step(input logic r, input logic fz, input logic fl, input logic ig,
                      input logic iv, input logic [11:0] sa, input logic [2:0] sv,
                      input logic [3:0] da, input logic wb, input logic ld);
    rst_n = r; freeze = fz; flush = fl; ignore_hazard = ig; id_valid = iv;
    src_addr = sa; src_valid = sv; dest_addr = da; dest_wb_en = wb; dest_is_load = ld;
    if (model_ok) push_expected();
    @(posedge clk);
    update_model();
    #1;
  endtask

  function automatic logic [11:0] srcs(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0);
    return {a2, a1, a0};
  endfunction

  task automatic rst2();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom),
           3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with random inputs, then confirm the cleared state
    rst2();
    for (int k = 0; k < NI; k++) begin
      check("reset pending_mask", k, 32'(pm[k]), 32'd0);
      check("reset stall_count",  k, sc[k], 32'd0);
    end
    step(1'b1, 0, 0, 0, 1, srcs(3, 2, 1), 3'b111, 4'd0, 0, 0);

    // load-use: LDR R3 then a reader of R3
    rst2();
    step(1'b1, 0, 0, 0, 1, 12'd0, 3'b000, 4'd3, 1, 1);
    step(1'b1, 0, 0, 0, 1, srcs(0, 0, 3), 3'b001, 4'd0, 0, 0);
    step(1'b1, 0, 0, 0, 1, srcs(0, 0, 3), 3'b001, 4'd0, 0, 0);
    check("load_use stall_count", 0, sc[0], 32'd1);
    check("load_use stall_count", 2, sc[2], 32'd2);

    // no forwarding: ADD R5 then reader on source 2
    rst2();
    step(1'b1, 0, 0, 0, 1, 12'd0, 3'b000, 4'd5, 1, 0);
    repeat (3) step(1'b1, 0, 0, 0, 1, srcs(5, 0, 0), 3'b100, 4'd0, 0, 0);
    check("nofwd stall_count", 1, sc[1], 32'd2);
    check("alu_fwd stall_count", 0, sc[0], 32'd0);
    rst2();
    step(1'b1, 0, 0, 0, 1, 12'd0, 3'b000, 4'd5, 1, 0);
    repeat (2) step(1'b1, 0, 0, 0, 1, srcs(5, 0, 0), 3'b011, 4'd0, 0, 0);
    check("nofwd src2 unread stall_count", 1, sc[1], 32'd0);

    // freeze mid-countdown
    rst2();
    step(1'b1, 0, 0, 0, 1, 12'd0, 3'b000, 4'd1, 1, 1);
    repeat (3) step(1'b1, 1, 0, 0, 1, srcs(0, 0, 1), 3'b001, 4'd0, 0, 0);
    check("freeze pending R1", 0, 32'(pm[0][1]), 32'd1);
    check("freeze stall_count", 0, sc[0], 32'd0);
    repeat (2) step(1'b1, 0, 0, 0, 1, srcs(0, 0, 1), 3'b001, 4'd0, 0, 0);
    check("after freeze stall_count", 0, sc[0], 32'd1);

    // WAW: LDR R2 then ADD R2 then readers of R2
    rst2();
    step(1'b1, 0, 0, 0, 1, 12'd0, 3'b000, 4'd2, 1, 1);
    step(1'b1, 0, 0, 0, 1, 12'd0, 3'b000, 4'd2, 1, 0);
    repeat (3) step(1'b1, 0, 0, 0, 1, srcs(0, 2, 0), 3'b010, 4'd0, 0, 0);
    check("waw fwd stall_count", 0, sc[0], 32'd0);
    check("waw ld2 stall_count", 2, sc[2], 32'd1);

    // ignore_hazard and flush while R4 is pending
    rst2();
    step(1'b1, 0, 0, 0, 1, 12'd0, 3'b000, 4'd4, 1, 1);
    step(1'b1, 0, 0, 1, 1, srcs(0, 0, 4), 3'b001, 4'd0, 0, 0);
    step(1'b1, 0, 1, 0, 1, srcs(0, 0, 4), 3'b001, 4'd0, 0, 0);
    check("flush stall_count", 2, sc[2], 32'd1);
    check("flush pending R4", 2, 32'(pm[2][4]), 32'd0);
    repeat (2) step(1'b1, 0, 0, 0, 1, srcs(0, 0, 4), 3'b001, 4'd0, 0, 0);

    // randomized traffic over a small register window to provoke hazards
    rst2();
    for (int n = 0; n < 800; n++) begin
      step(1'(($urandom_range(0, 99)) != 0),
           1'(($urandom_range(0, 5)) == 0),
           1'(($urandom_range(0, 7)) == 0),
           1'(($urandom_range(0, 7)) == 0),
           1'(($urandom_range(0, 3)) != 0),
           srcs(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))),
           3'($urandom),
           4'($urandom_range(0, 7)),
           1'(($urandom_range(0, 3)) != 0),
           1'(($urandom_range(0, 2)) == 0));
    end

    step(1'b1, 0, 0, 0, 0, 12'd0, 3'b000, 4'd0, 0, 0);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
